mem_arbiter: RTL and testbench

Shared-memory arbiter and sequencer between the instruction-fetch port and the data-memory port of the 5-stage pipeline. It owns the single unified RAM port and grants one access at a time, with data priority and alternation under contention. It stalls the losing stage, and drives the stall_if / stall_mem inputs of the pipeline control alongside the hazard unit's stalls.

---
 rtl/mem_arbiter_if.sv | 41 ++++
 rtl/mem_arbiter.sv | 117 +++++++++++
 tb/tb_mem_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, data and RAM handshake signals around the memory arbiter.
// The arbiter uses the slave view; the pipeline/RAM environment uses the master view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic              ram_req;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_ack;

    logic              stall_if;
    logic              stall_mem;
    logic              busy;

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata, ram_ack,
        output if_rdata, if_ready, mem_rdata, mem_ready,
        output ram_req, ram_we, ram_addr, ram_wdata, stall_if, stall_mem, busy
    );

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata, ram_ack,
        input  if_rdata, if_ready, mem_rdata, mem_ready,
        input  ram_req, ram_we, ram_addr, ram_wdata, stall_if, stall_mem, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shared-memory arbiter: grants the single RAM port to either the data or the
// fetch requester, data first under contention unless data won last time.
//
// state | meaning
// IDLE  | no access in flight, arbitrate on this edge
// GNT_D | data access issued to RAM, waiting for ram_ack
// GNT_I | fetch access issued to RAM, waiting for ram_ack
// RESP  | one-cycle ready pulse to the granted requester
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GNT_D = 2'd1;
    localparam logic [1:0] GNT_I = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic INST = 1'b0;
    localparam logic DATA = 1'b1;

    logic [1:0]        state;
    logic              last_grant;
    logic              grant_data;
    logic              grant_inst;
    logic              ram_req;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] if_rdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              if_ready;
    logic              mem_ready;

    // Arbitration: data wins unless both request and data had the previous grant.
    always_comb begin
        grant_data = bus.mem_req & (~bus.if_req | (last_grant == INST));
        grant_inst = bus.if_req & ~grant_data;
    end

    // Sequencer: grant, hold the RAM request until ack, then pulse ready once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= INST;
            ram_req    <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            if_rdata   <= '0;
            mem_rdata  <= '0;
            if_ready   <= 1'b0;
            mem_ready  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_data) begin
                        ram_req    <= 1'b1;
                        ram_we     <= bus.mem_we;
                        ram_addr   <= bus.mem_addr;
                        ram_wdata  <= bus.mem_wdata;
                        last_grant <= DATA;
                        state      <= GNT_D;
                    end else if (grant_inst) begin
                        ram_req    <= 1'b1;
                        ram_we     <= 1'b0;
                        ram_addr   <= bus.if_addr;
                        ram_wdata  <= '0;
                        last_grant <= INST;
                        state      <= GNT_I;
                    end
                end
                GNT_D: begin
                    if (bus.ram_ack) begin
                        // a store leaves the last load result in place
                        if (!ram_we) begin
                            mem_rdata <= bus.ram_rdata;
                        end
                        ram_req   <= 1'b0;
                        ram_we    <= 1'b0;
                        mem_ready <= 1'b1;
                        state     <= RESP;
                    end
                end
                GNT_I: begin
                    if (bus.ram_ack) begin
                        if_rdata <= bus.ram_rdata;
                        ram_req  <= 1'b0;
                        ram_we   <= 1'b0;
                        if_ready <= 1'b1;
                        state    <= RESP;
                    end
                end
                default: begin
                    if_ready  <= 1'b0;
                    mem_ready <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.ram_req   = ram_req;
    assign bus.ram_we    = ram_we;
    assign bus.ram_addr  = ram_addr;
    assign bus.ram_wdata = ram_wdata;
    assign bus.if_rdata  = if_rdata;
    assign bus.mem_rdata = mem_rdata;
    assign bus.if_ready  = if_ready;
    assign bus.mem_ready = mem_ready;
    assign bus.busy      = (state != IDLE);
    assign bus.stall_if  = bus.if_req & ~if_ready;
    assign bus.stall_mem = bus.mem_req & ~mem_ready;
endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: table of access scenarios, hand sequences for flush,
// sustained contention and reset mid-access, and a randomized run, all checked
// against a transaction-level model of requesters, RAM and arbitration rules.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();
    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit          req_i;
        bit          req_m;
        bit          we_m;
        logic [31:0] addr_i;
        logic [31:0] addr_m;
        logic [31:0] wdata_m;
        logic [31:0] rdata_i;
        logic [31:0] rdata_m;
        bit          pre_m;
        int          wait_c;
        bit          exp_first_d;
        logic [31:0] exp_if_rdata;
        logic [31:0] exp_mem_rdata;
    } vec_t;
    vec_t vt[6];

    // model of the access stream: phase 0 = nothing in flight, 1 = RAM access, 2 = ready cycle
    int          phase;
    int          act_port;
    logic [31:0] act_addr, act_wdata, ack_data;
    logic        act_we, ack_sent, last_d;
    int          wait_left, fixed_wait;
    logic [31:0] exp_if_rdata, exp_mem_rdata;
    logic [31:0] mem_model [logic [31:0]];
    int          grant_log[$];
    int          rc_i, rc_m;
    // requester model
    bit          rand_mode, out_i, out_m, pend_i, pend_m, flush_i, flush_m, keep_i, keep_m;
    logic [31:0] pend_i_addr, pend_m_addr, pend_m_wdata;
    logic        pend_m_we;
    logic        prv_req_i, prv_req_m, prv_m_we;
    logic [31:0] prv_i_addr, prv_m_addr, prv_m_wdata;

    task automatic chk1(string name, logic act, logic req_v);
        n_checks++;
        if (act !== req_v) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, req_v, $time);
        end
    endtask

    task automatic chk32(string name, logic [31:0] act, logic [31:0] req_v);
        n_checks++;
        if (act !== req_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req_v, $time);
        end
    endtask

    function automatic logic [31:0] mem_rd(logic [31:0] a);
        return mem_model.exists(a) ? mem_model[a] : (a ^ 32'h5A5A_0000);
    endfunction

    task automatic record_prev();
        prv_req_i   = bus.if_req;
        prv_req_m   = bus.mem_req;
        prv_i_addr  = bus.if_addr;
        prv_m_addr  = bus.mem_addr;
        prv_m_we    = bus.mem_we;
        prv_m_wdata = bus.mem_wdata;
    endtask

    task automatic model_reset();
        phase = 0; act_port = -1; ack_sent = 1'b0; last_d = 1'b0;
        exp_if_rdata = '0; exp_mem_rdata = '0;
        out_i = 0; out_m = 0; pend_i = 0; pend_m = 0;
        flush_i = 0; flush_m = 0; keep_i = 0; keep_m = 0;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;
        bus.ram_ack = 1'b0; bus.ram_rdata = '0;
        record_prev();
    endtask

    // advance the model across the clock edge just passed and compare all outputs
    task automatic step_check();
        int gp;
        logic rdy_i, rdy_m;
        case (phase)
            1: if (ack_sent) begin
                phase = 2; ack_sent = 1'b0;
                if (act_port == 0) begin
                    exp_if_rdata = ack_data; rc_i++;
                end else begin
                    if (act_we) mem_model[act_addr] = act_wdata;
                    else        exp_mem_rdata = ack_data;
                    rc_m++;
                end
            end
            2: phase = 0;
            default: if (prv_req_i || prv_req_m) begin
                gp = (prv_req_i && prv_req_m) ? (last_d ? 0 : 1) : (prv_req_m ? 1 : 0);
                last_d    = (gp == 1);
                phase     = 1;
                act_port  = gp;
                act_addr  = gp == 1 ? prv_m_addr : prv_i_addr;
                act_we    = gp == 1 ? prv_m_we : 1'b0;
                act_wdata = gp == 1 ? prv_m_wdata : 32'h0;
                wait_left = fixed_wait >= 0 ? fixed_wait : int'($urandom_range(0, 4));
                grant_log.push_back(gp);
            end
        endcase
        rdy_i = (phase == 2) && (act_port == 0);
        rdy_m = (phase == 2) && (act_port == 1);
        chk1("ram_req", bus.ram_req, phase == 1);
        chk1("busy", bus.busy, phase != 0);
        chk1("if_ready", bus.if_ready, rdy_i);
        chk1("mem_ready", bus.mem_ready, rdy_m);
        chk32("if_rdata", bus.if_rdata, exp_if_rdata);
        chk32("mem_rdata", bus.mem_rdata, exp_mem_rdata);
        chk1("stall_if", bus.stall_if, bus.if_req & ~rdy_i);
        chk1("stall_mem", bus.stall_mem, bus.mem_req & ~rdy_m);
        if (phase == 1) begin
            chk32("ram_addr", bus.ram_addr, act_addr);
            chk1("ram_we", bus.ram_we, act_we);
            chk32("ram_wdata", bus.ram_wdata, act_wdata);
        end else begin
            chk1("ram_we_off", bus.ram_we, 1'b0);
        end
    endtask

    // drive RAM response and requester behaviour for the coming edge
    task automatic step_drive();
        if (phase == 1) begin
            if (wait_left == 0) begin
                ack_data = act_we ? $urandom : mem_rd(act_addr);
                bus.ram_ack = 1'b1; bus.ram_rdata = ack_data; ack_sent = 1'b1;
            end else begin
                wait_left--;
                bus.ram_ack = 1'b0; bus.ram_rdata = $urandom;
            end
        end else begin
            bus.ram_ack = rand_mode && ($urandom_range(0, 3) == 0);
            bus.ram_rdata = $urandom;
        end
        if (rand_mode && !out_i && !pend_i && $urandom_range(0, 2) == 0) begin
            pend_i = 1; pend_i_addr = 32'($urandom_range(0, 63)) << 2;
        end
        if (rand_mode && !out_m && !pend_m && $urandom_range(0, 2) == 0) begin
            pend_m = 1; pend_m_addr = 32'h1000 | (32'($urandom_range(0, 15)) << 2);
            pend_m_we = 1'($urandom_range(0, 1)); pend_m_wdata = $urandom;
        end
        if (phase == 2 && act_port == 0) begin
            bus.if_req = 1'b0; out_i = 0;
        end else if (out_i && bus.if_req && phase == 1 && act_port == 0 &&
                     (flush_i || (rand_mode && $urandom_range(0, 9) == 0))) begin
            bus.if_req = 1'b0; flush_i = 0;
        end else if (!out_i && (pend_i || keep_i)) begin
            if (!pend_i) pend_i_addr = 32'h80;
            bus.if_req = 1'b1; bus.if_addr = pend_i_addr; out_i = 1; pend_i = 0;
        end
        if (phase == 2 && act_port == 1) begin
            bus.mem_req = 1'b0; out_m = 0;
        end else if (out_m && bus.mem_req && phase == 1 && act_port == 1 &&
                     (flush_m || (rand_mode && $urandom_range(0, 9) == 0))) begin
            bus.mem_req = 1'b0; flush_m = 0;
        end else if (!out_m && (pend_m || keep_m)) begin
            if (!pend_m) begin
                pend_m_addr = 32'h180; pend_m_we = 1'b0; pend_m_wdata = '0;
            end
            bus.mem_req = 1'b1; bus.mem_addr = pend_m_addr; bus.mem_we = pend_m_we;
            bus.mem_wdata = pend_m_wdata; out_m = 1; pend_m = 0;
        end
        record_prev();
    endtask

    task automatic cycle();
        @(negedge clk);
        step_check();
        step_drive();
    endtask

    task automatic run_until_idle(int limit, string name);
        bit done = 0;
        for (int c = 0; c < limit && !done; c++) begin
            cycle();
            done = (phase == 0) && !out_i && !out_m && !pend_i && !pend_m &&
                   !bus.if_req && !bus.mem_req;
        end
        chk1({"drain_", name}, done, 1'b1);
    endtask

    initial begin
        vt[0] = '{1, 0, 0, 32'h40, 32'h0,   32'h0,         32'h2008_0005, 32'h0,         0, 0, 0, 32'h2008_0005, 32'h0};
        vt[1] = '{1, 1, 0, 32'h44, 32'h100, 32'h0,         32'h1234_5678, 32'hCAFE_0100, 1, 0, 1, 32'h1234_5678, 32'hCAFE_0100};
        vt[2] = '{0, 1, 1, 32'h0,  32'h200, 32'hDEAD_BEEF, 32'h0,         32'h0,         0, 4, 1, 32'h1234_5678, 32'hCAFE_0100};
        vt[3] = '{1, 1, 0, 32'h48, 32'h200, 32'h0,         32'h0BAD_F00D, 32'h0,         0, 2, 0, 32'h0BAD_F00D, 32'hDEAD_BEEF};
        vt[4] = '{0, 1, 0, 32'h0,  32'h300, 32'h0,         32'h0,         32'h5555_AAAA, 1, 1, 1, 32'h0BAD_F00D, 32'h5555_AAAA};
        vt[5] = '{1, 1, 1, 32'h4C, 32'h304, 32'h7777_0000, 32'h0000_0001, 32'h0,         0, 0, 0, 32'h0000_0001, 32'h5555_AAAA};

        rand_mode = 0; fixed_wait = 0; rc_i = 0; rc_m = 0;
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        chk1("rst_ram_req", bus.ram_req, 1'b0);
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_if_ready", bus.if_ready, 1'b0);
        chk1("rst_mem_ready", bus.mem_ready, 1'b0);
        chk32("rst_ram_addr", bus.ram_addr, 32'h0);
        chk32("rst_if_rdata", bus.if_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // table-driven scenarios, applied back to back so arbitration history carries over
        for (int k = 0; k < 6; k++) begin
            grant_log.delete(); rc_i = 0; rc_m = 0;
            fixed_wait = vt[k].wait_c;
            if (vt[k].req_i) begin
                mem_model[vt[k].addr_i] = vt[k].rdata_i;
                pend_i = 1; pend_i_addr = vt[k].addr_i;
            end
            if (vt[k].req_m) begin
                if (vt[k].pre_m) mem_model[vt[k].addr_m] = vt[k].rdata_m;
                pend_m = 1; pend_m_addr = vt[k].addr_m;
                pend_m_we = vt[k].we_m; pend_m_wdata = vt[k].wdata_m;
            end
            run_until_idle(40, "vec");
            chk32("vec_first_grant", grant_log.size() > 0 ? 32'(grant_log[0]) : 32'd2,
                  32'(vt[k].exp_first_d));
            chk32("vec_num_grants", 32'(grant_log.size()), 32'(vt[k].req_i) + 32'(vt[k].req_m));
            chk32("vec_if_ready_count", 32'(rc_i), 32'(vt[k].req_i));
            chk32("vec_mem_ready_count", 32'(rc_m), 32'(vt[k].req_m));
            chk32("vec_if_rdata", bus.if_rdata, vt[k].exp_if_rdata);
            chk32("vec_mem_rdata", bus.mem_rdata, vt[k].exp_mem_rdata);
        end

        // flush: fetch request withdrawn one cycle after its grant
        rc_i = 0; fixed_wait = 2;
        mem_model[32'h50] = 32'h600D_0050;
        pend_i = 1; pend_i_addr = 32'h50; flush_i = 1;
        run_until_idle(30, "flush");
        chk32("flush_if_ready_count", 32'(rc_i), 32'd1);
        chk32("flush_if_rdata", bus.if_rdata, 32'h600D_0050);
        for (int c = 0; c < 3; c++) cycle();

        // sustained contention: both ports re-request immediately after each ready
        grant_log.delete(); fixed_wait = 1;
        keep_i = 1; keep_m = 1;
        for (int c = 0; c < 40; c++) cycle();
        keep_i = 0; keep_m = 0;
        run_until_idle(30, "sustain");
        chk1("sustain_enough_grants", grant_log.size() >= 8, 1'b1);
        for (int k = 1; k < grant_log.size(); k++)
            chk1("sustain_alternates", grant_log[k] != grant_log[k-1], 1'b1);

        // randomized traffic with random RAM latency, spurious acks and flushes
        rand_mode = 1; fixed_wait = -1;
        for (int c = 0; c < 1500; c++) cycle();
        rand_mode = 0; fixed_wait = 0;
        run_until_idle(60, "random");

        // reset in the middle of a data access
        rc_m = 0; fixed_wait = 10;
        pend_m = 1; pend_m_addr = 32'h380; pend_m_we = 1'b1; pend_m_wdata = 32'h1357_9BDF;
        for (int c = 0; c < 10 && !(phase == 1 && act_port == 1); c++) cycle();
        cycle();
        chk1("pre_rst_ram_req", bus.ram_req, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk1("midrst_ram_req", bus.ram_req, 1'b0);
        chk1("midrst_ram_we", bus.ram_we, 1'b0);
        chk32("midrst_ram_addr", bus.ram_addr, 32'h0);
        chk32("midrst_ram_wdata", bus.ram_wdata, 32'h0);
        chk1("midrst_busy", bus.busy, 1'b0);
        chk1("midrst_mem_ready", bus.mem_ready, 1'b0);
        chk32("midrst_if_rdata", bus.if_rdata, 32'h0);
        chk32("midrst_mem_rdata", bus.mem_rdata, 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        rc_m = 0;
        for (int c = 0; c < 4; c++) cycle();
        chk32("midrst_no_mem_ready", 32'(rc_m), 32'd0);
        grant_log.delete(); fixed_wait = 0;
        mem_model[32'h100] = 32'hA1A1_0100;
        pend_i = 1; pend_i_addr = 32'h40;
        pend_m = 1; pend_m_addr = 32'h100; pend_m_we = 1'b0; pend_m_wdata = '0;
        run_until_idle(30, "post_rst");
        chk32("post_rst_first_grant", grant_log.size() > 0 ? 32'(grant_log[0]) : 32'd2, 32'd1);
        chk32("post_rst_mem_rdata", bus.mem_rdata, 32'hA1A1_0100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end
endmodule
